regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the multi-port register file
package regfile_pkg;

   localparam logic ENABLE    = 1'b1;
   localparam logic DISABLE   = 1'b0;
   localparam int   ZERO_ADDR = 0;

   // Address width for a register count; a single register still gets one bit.
   function automatic int ADDR_W(input int nregs);
      return (nregs <= 1) ? 1 : $clog2(nregs);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with reserve/release/flush and read lookup
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = ADDR_W(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   input  logic [NWR-1:0]    clr_en,
   input  logic [NWR*AW-1:0] clr_addr,
   input  logic [NRD*AW-1:0] look_addr,
   output logic [NRD-1:0]    look_busy
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;

   // Releases are applied first so a same-cycle reservation of a new producer wins.
   always_comb begin
      busy_nxt = busy;
      for (int w = 0; w < NWR; w++) begin
         if (clr_en[w]) begin
            busy_nxt[clr_addr[w*AW +: AW]] = DISABLE;
         end
      end
      if (rsv_en) begin
         busy_nxt[rsv_addr] = ENABLE;
      end
      if (ZERO_REG != 0) begin
         busy_nxt[ZERO_ADDR] = DISABLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   always_comb begin
      look_busy = '0;
      for (int p = 0; p < NRD; p++) begin
         look_busy[p] = busy[look_addr[p*AW +: AW]];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-to-read bypass and busy scoreboard
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = ADDR_W(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   input  logic                flush,
   output logic                wr_conflict
);

   logic [XLEN-1:0] regs [NREGS];
   logic [AW-1:0]   wr_a [NWR];
   logic [XLEN-1:0] wr_d [NWR];
   logic [NWR-1:0]  wr_vld;
   logic [AW-1:0]   rd_a [NRD];
   logic [NRD-1:0]  byp_hit;
   logic [NRD-1:0]  rsv_hit;
   logic [NRD-1:0]  sb_busy;
   logic            rsv_vld;
   logic            conflict_c;

   // Writes to the hardwired zero register are dropped before they reach anything.
   for (genvar w = 0; w < NWR; w++) begin : g_wr
      assign wr_a[w]   = wr_addr[w*AW +: AW];
      assign wr_d[w]   = wr_data[w*XLEN +: XLEN];
      assign wr_vld[w] = wr_en[w] && !((ZERO_REG != 0) && (wr_a[w] == AW'(ZERO_ADDR)));
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      assign rd_a[p] = rd_addr[p*AW +: AW];
   end

   assign rsv_vld = rsv_en && !((ZERO_REG != 0) && (rsv_addr == AW'(ZERO_ADDR)));

   always_comb begin
      conflict_c = DISABLE;
      for (int i = 0; i < NWR; i++) begin
         for (int j = i + 1; j < NWR; j++) begin
            if (wr_vld[i] && wr_vld[j] && (wr_a[i] == wr_a[j])) begin
               conflict_c = ENABLE;
            end
         end
      end
   end

   // Later ports overwrite earlier ones, so the highest-index port wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
         wr_conflict <= DISABLE;
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (wr_vld[w]) begin
               regs[wr_a[w]] <= wr_d[w];
            end
         end
         wr_conflict <= conflict_c;
      end
   end

   always_comb begin
      rd_data = '0;
      byp_hit = '0;
      rsv_hit = '0;
      for (int p = 0; p < NRD; p++) begin
         rd_data[p*XLEN +: XLEN] = regs[rd_a[p]];
         if (BYPASS != 0) begin
            for (int w = 0; w < NWR; w++) begin
               if (wr_vld[w] && (wr_a[w] == rd_a[p])) begin
                  rd_data[p*XLEN +: XLEN] = wr_d[w];
                  byp_hit[p] = ENABLE;
               end
            end
         end
         if ((ZERO_REG != 0) && (rd_a[p] == AW'(ZERO_ADDR))) begin
            rd_data[p*XLEN +: XLEN] = '0;
         end
         rsv_hit[p] = rsv_vld && (rsv_addr == rd_a[p]);
      end
   end

   // A bypassed value is usable now unless a new producer claims the register this cycle.
   assign rd_busy = sb_busy & ~(byp_hit & ~rsv_hit);

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .NRD      (NRD),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .rsv_en    (rsv_vld),
      .rsv_addr  (rsv_addr),
      .clr_en    (wr_vld),
      .clr_addr  (wr_addr),
      .look_addr (rd_addr),
      .look_busy (sb_busy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp in bypass/zero and plain configurations
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int NWR   = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                flush;

   logic [NRD*XLEN-1:0] rd_data_a, rd_data_b;
   logic [NRD-1:0]      rd_busy_a, rd_busy_b;
   logic                conf_a, conf_b;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
      .rsv_addr(rsv_addr), .flush(flush), .wr_conflict(conf_a)
   );

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
      .rsv_addr(rsv_addr), .flush(flush), .wr_conflict(conf_b)
   );

   typedef struct packed {
      logic [NRD*XLEN-1:0] d_a;
      logic [NRD*XLEN-1:0] d_b;
      logic [NRD-1:0]      b_a;
      logic [NRD-1:0]      b_b;
      logic                c_a;
      logic                c_b;
      int                  cyc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference state per configuration: index 0 = zero reg + bypass, 1 = plain.
   logic [XLEN-1:0] m_reg  [2][NREGS];
   bit              m_busy [2][NREGS];
   bit              m_conf [2];
   bit              cfg_zero [2] = '{1'b1, 1'b0};
   bit              cfg_byp  [2] = '{1'b1, 1'b0};

   function automatic int wa(input int w);
      return int'(wr_addr[w*AW +: AW]);
   endfunction

   function automatic logic [XLEN-1:0] wd(input int w);
      return wr_data[w*XLEN +: XLEN];
   endfunction

   function automatic bit write_hits(input int c, input int a);
      for (int w = 0; w < NWR; w++)
         if (wr_en[w] && wa(w) == a && !(cfg_zero[c] && a == 0)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [XLEN-1:0] exp_read(input int c, input int a);
      logic [XLEN-1:0] d;
      if (cfg_zero[c] && a == 0) return '0;
      d = m_reg[c][a];
      if (cfg_byp[c])
         for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wa(w) == a) d = wd(w);
      return d;
   endfunction

   function automatic bit exp_busy(input int c, input int a);
      if (cfg_zero[c] && a == 0) return 1'b0;
      if (cfg_byp[c] && write_hits(c, a) && !(rsv_en && int'(rsv_addr) == a)) return 1'b0;
      return m_busy[c][a];
   endfunction

   task automatic model_edge();
      for (int c = 0; c < 2; c++) begin
         if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
               m_reg[c][r]  = '0;
               m_busy[c][r] = 1'b0;
            end
            m_conf[c] = 1'b0;
         end else begin
            m_conf[c] = 1'b0;
            for (int i = 0; i < NWR; i++)
               for (int j = i + 1; j < NWR; j++)
                  if (wr_en[i] && wr_en[j] && wa(i) == wa(j) && !(cfg_zero[c] && wa(i) == 0))
                     m_conf[c] = 1'b1;
            for (int r = 0; r < NREGS; r++) begin
               if (flush) m_busy[c][r] = 1'b0;
               else if (rsv_en && int'(rsv_addr) == r && !(cfg_zero[c] && r == 0)) m_busy[c][r] = 1'b1;
               else if (write_hits(c, r)) m_busy[c][r] = 1'b0;
            end
            for (int w = 0; w < NWR; w++)
               if (wr_en[w] && !(cfg_zero[c] && wa(w) == 0)) m_reg[c][wa(w)] = wd(w);
         end
      end
   endtask

   task automatic step(input bit r, input bit [1:0] we,
                       input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                       input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input bit re, input logic [AW-1:0] radr, input bit fl);
      exp_t e;
      rst = r; wr_en = we; wr_addr = {a1, a0}; wr_data = {d1, d0};
      rd_addr = {ra1, ra0}; rsv_en = re; rsv_addr = radr; flush = fl;
      if (!r) begin
         e.d_a = {exp_read(0, int'(ra1)), exp_read(0, int'(ra0))};
         e.d_b = {exp_read(1, int'(ra1)), exp_read(1, int'(ra0))};
         e.b_a = {exp_busy(0, int'(ra1)), exp_busy(0, int'(ra0))};
         e.b_b = {exp_busy(1, int'(ra1)), exp_busy(1, int'(ra0))};
         e.c_a = m_conf[0];
         e.c_b = m_conf[1];
         e.cyc = cyc;
         sbq.push_back(e);
      end
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
   endtask

   task automatic rd(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      step(0, 2'b00, 0, 0, 0, 0, ra0, ra1, 0, 0, 0);
   endtask

   task automatic chk(input string nm, input int c, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d actual=%h expected=%h", nm, c, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("a_rd_data0", e.cyc, rd_data_a[XLEN-1:0],      e.d_a[XLEN-1:0]);
         chk("a_rd_data1", e.cyc, rd_data_a[2*XLEN-1:XLEN], e.d_a[2*XLEN-1:XLEN]);
         chk("a_rd_busy",  e.cyc, XLEN'(rd_busy_a),         XLEN'(e.b_a));
         chk("a_conflict", e.cyc, XLEN'(conf_a),            XLEN'(e.c_a));
         chk("b_rd_data0", e.cyc, rd_data_b[XLEN-1:0],      e.d_b[XLEN-1:0]);
         chk("b_rd_data1", e.cyc, rd_data_b[2*XLEN-1:XLEN], e.d_b[2*XLEN-1:XLEN]);
         chk("b_rd_busy",  e.cyc, XLEN'(rd_busy_b),         XLEN'(e.b_b));
         chk("b_conflict", e.cyc, XLEN'(conf_b),            XLEN'(e.c_b));
      end
   end

   initial begin
      logic [AW-1:0] a0, a1, r0, r1, ra;
      rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
      @(posedge clk); #1;

      step(1, 2'b01, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
      step(1, 2'b01, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
      for (int a = 0; a < NREGS; a++) rd(AW'(a), AW'(NREGS - 1 - a));

      step(0, 2'b01, 3, 32'hDEAD_BEEF, 0, 0, 3, 5, 0, 0, 0);
      rd(3, 3);

      step(0, 2'b11, 7, 32'h11, 7, 32'h22, 7, 0, 0, 0, 0);
      rd(7, 7);
      rd(7, 0);
      step(0, 2'b11, 0, 32'h33, 0, 32'h44, 0, 7, 0, 0, 0);
      rd(0, 0);
      rd(0, 7);

      step(0, 2'b00, 0, 0, 0, 0, 9, 1, 1, 9, 0);
      rd(9, 9);
      step(0, 2'b10, 0, 0, 9, 32'hCAFE_0009, 9, 2, 0, 0, 0);
      rd(9, 2);
      step(0, 2'b01, 9, 32'h0000_0999, 0, 0, 9, 9, 1, 9, 0);
      rd(9, 9);

      step(0, 2'b11, 4, 32'h44, 5, 32'h55, 4, 5, 1, 4, 0);
      step(0, 2'b01, 6, 32'h66, 0, 0, 6, 4, 1, 5, 0);
      step(0, 2'b00, 0, 0, 0, 0, 5, 6, 1, 6, 0);
      rd(4, 5);
      step(0, 2'b00, 0, 0, 0, 0, 6, 9, 0, 0, 1);
      rd(4, 5);
      rd(6, 9);

      step(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      rd(0, 0);
      step(0, 2'b01, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
      rd(0, 0);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            a0 = AW'($urandom_range(0, 7)); a1 = AW'($urandom_range(0, 7));
            r0 = AW'($urandom_range(0, 7)); r1 = AW'($urandom_range(0, 7));
            ra = AW'($urandom_range(0, 7));
         end else begin
            a0 = AW'($urandom); a1 = AW'($urandom);
            r0 = AW'($urandom); r1 = AW'($urandom); ra = AW'($urandom);
         end
         step($urandom_range(0, 199) == 0, 2'($urandom), a0, $urandom, a1, $urandom,
              r0, r1, $urandom_range(0, 3) == 0, ra, $urandom_range(0, 31) == 0);
      end

      rd(0, 1);
      for (int t = 0; t < 10 && sbq.size() > 0; t++) @(posedge clk);
      if (sbq.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
